fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage pipeline. It owns the PC and drives the instruction-memory request. It fills the IF/ID latch consumed by decode and the hazard unit. It consumes the hazard unit's `hazard`, `branch` and `jump` outputs to stall, redirect and squash. It also keeps the request address stable across a pending memory access, so a redirect that arrives mid-access is buffered until the access completes.

## Interface
- `PC_INIT`, 32'h0000_0000, PC value loaded on reset.
- `CLK`  in  1  system clock, rising-edge.
- `nRST`  in  1  asynchronous active-low reset.
- `ihit`  in  1  instruction memory returns `imemload` for `imemaddr` this cycle.
- `imemload`  in  32  fetched instruction word.
- `hazard`  in  1  stall request from hazard unit.
- `branch`  in  1  taken branch resolved in decode.
- `jump`  in  1  jump resolved in decode.
- `branch_target`  in  32  branch destination.
- `jump_target`  in  32  jump destination (J/JAL/JR, pre-selected upstream).
- `halt`  in  1  halt retired downstream; sticky shutdown of fetch.
- `imemREN`  out  1  instruction read request.
- `imemaddr`  out  32  request address (= PC).
- `ifid_instr`  out  32  IF/ID instruction; 0 (NOP) when invalid.
- `ifid_npc`  out  32  IF/ID PC+4 of the held instruction.
- `ifid_valid`  out  1  IF/ID holds a real instruction.
- `fetch_state`  out  2  debug: 0 RUN, 1 REDIR, 2 HALTED.

## Operation
- PC register drives `imemaddr`. Bits [1:0] of any loaded target are forced to 0. PC+4 wraps modulo 2^32.
- Redirect target: `jump` has priority over `branch`; `redir = jump | branch`.
- Memory rule: once `imemREN` is high with address A, A holds until `ihit`. Exceptions are reset and entry to HALTED.
- RUN (imemREN=1), priority per cycle:
  1. `halt`: go to HALTED; IF/ID becomes a bubble.
  2. `redir & ihit`: PC <= target; IF/ID bubble (squash the wrong-path fetch).
  3. `redir & !ihit`: latch target into `pend_pc`; go to REDIR; IF/ID bubble; PC holds.
  4. `hazard`: PC and IF/ID hold. A returning `ihit` word is discarded and refetched later.
  5. `ihit`: IF/ID <= {imemload, PC+4, valid=1}; PC <= PC+4.
  6. Otherwise: IF/ID bubble; PC holds.
- REDIR (imemREN=1, address = old PC):
  - `halt` goes to HALTED.
  - New `redir` overwrites `pend_pc`, jump first.
  - On `ihit`: discard `imemload`; PC <= `pend_pc`; go to RUN.
  - IF/ID stays a bubble throughout.
  - `hazard` is ignored.
- HALTED: imemREN=0; PC frozen; IF/ID bubble. Exit only through reset.
- Bubble = {instr 0, npc 0, valid 0}.

## Timing
- Reset (async, `nRST` low):
  - PC = PC_INIT; state RUN; `pend_pc` = 0.
  - `ifid_instr` = 0, `ifid_npc` = 0, `ifid_valid` = 0.
  - `imemREN` = 1 and `imemaddr` = PC_INIT immediately on release. `fetch_state` = 0.
- `imemREN`, `imemaddr` and `fetch_state` are decoded from registers, not from inputs. No combinational path from inputs to outputs.
- Fetch latency: IF/ID is valid the edge after the `ihit` cycle. With continuous `ihit` the throughput is 1 instruction per cycle.
- Redirect penalty: one bubble if `ihit` arrives in the redirect cycle. Otherwise one bubble, plus one bubble per REDIR cycle, plus the refetch of the target.
- `halt`, `redir` and `ihit` in the same cycle: halt wins and nothing is latched.
- Reset asserted mid-REDIR: the pending target is lost and fetch restarts at PC_INIT.

## Test plan
- Reset, `ihit`=1 for 4 cycles, imemload = 0xA0..0xA3 → `imemaddr` 0,4,8,C. IF/ID gets 0xA0/npc 4 one edge after the first `ihit`, then one instruction per cycle.
- `hazard`=1 for 2 cycles with `ihit`=1 at PC=8 → PC holds at 8, IF/ID holds its previous value. After release, 8 is refetched.
- `branch`=1, target 0x40, `ihit`=1 → next `imemaddr`=0x40, IF/ID bubble for one cycle, then the 0x40 word arrives. Repeat with `jump` and `branch` together (jump 0x80, branch 0x40) → 0x80.
- `jump`=1 (0x100) with `ihit`=0 at PC=0xC, `ihit` delayed 3 cycles → `imemaddr` stays 0xC, `fetch_state`=1, the returned word is discarded. Then `imemaddr`=0x100. Target 0x103 loads 0x100.
- PC=0xFFFF_FFFC with `ihit` → PC wraps to 0.
- `halt` while in REDIR → `imemREN`=0, PC frozen, IF/ID invalid. Mid-run `nRST` pulse → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch stage: PC, imem request, IF/ID latch, redirect buffering
//
// Purpose: owns the PC and the instruction-memory request, fills the IF/ID
// latch, and applies stall / redirect / squash / halt from the hazard unit.
// The request address is held stable until ihit; a redirect that arrives
// while an access is still pending is parked in pend_pc (REDIR state).
//
// Ports:
//   CLK, nRST                  clock (rising edge), async active-low reset
//   ihit, imemload             memory returns imemload for imemaddr this cycle
//   hazard                     stall request
//   branch/branch_target       taken branch resolved in decode
//   jump/jump_target           jump resolved in decode (priority over branch)
//   halt                       sticky shutdown of fetch
//   imemREN, imemaddr          instruction read request / address (= PC)
//   ifid_instr/npc/valid       IF/ID latch (bubble = all zero)
//   fetch_state                debug: 0 RUN, 1 REDIR, 2 HALTED
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        hazard,
  input  logic        branch,
  input  logic        jump,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_npc,
  output logic        ifid_valid,
  output logic [1:0]  fetch_state
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_REDIR  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t      r_state, w_state_n;
  logic [31:0] r_pc, w_pc_n;
  logic [31:0] r_pend_pc, w_pend_n;
  logic [31:0] r_instr, w_instr_n;
  logic [31:0] r_npc, w_npc_n;
  logic        r_valid, w_valid_n;

  logic        w_redir;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;

  assign w_redir    = jump | branch;
  // Targets are always word aligned; low bits of the raw address are dropped.
  assign w_target   = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;
  assign w_pc_plus4 = r_pc + 32'd4;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= S_RUN;
      r_pc      <= PC_INIT;
      r_pend_pc <= 32'd0;
      r_instr   <= 32'd0;
      r_npc     <= 32'd0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_pc      <= w_pc_n;
      r_pend_pc <= w_pend_n;
      r_instr   <= w_instr_n;
      r_npc     <= w_npc_n;
      r_valid   <= w_valid_n;
    end
  end

  always_comb begin
    // Default: PC and pending target hold, IF/ID becomes a bubble.
    w_state_n = r_state;
    w_pc_n    = r_pc;
    w_pend_n  = r_pend_pc;
    w_instr_n = 32'd0;
    w_npc_n   = 32'd0;
    w_valid_n = 1'b0;
    case (r_state)
      S_RUN: begin
        if (halt) begin
          w_state_n = S_HALTED;
        end else if (w_redir && ihit) begin
          w_pc_n = w_target;
        end else if (w_redir) begin
          // Access still outstanding: keep the address, remember the target.
          w_pend_n  = w_target;
          w_state_n = S_REDIR;
        end else if (hazard) begin
          // Stall: the returning word (if any) is dropped and refetched.
          w_instr_n = r_instr;
          w_npc_n   = r_npc;
          w_valid_n = r_valid;
        end else if (ihit) begin
          w_instr_n = imemload;
          w_npc_n   = w_pc_plus4;
          w_valid_n = 1'b1;
          w_pc_n    = w_pc_plus4;
        end
      end
      S_REDIR: begin
        if (halt) begin
          w_state_n = S_HALTED;
        end else if (ihit) begin
          // Wrong-path word is discarded; a redirect arriving this same cycle
          // is younger than the parked one and wins.
          w_pc_n    = w_redir ? w_target : r_pend_pc;
          w_state_n = S_RUN;
        end else if (w_redir) begin
          w_pend_n = w_target;
        end
      end
      S_HALTED: begin
        w_state_n = S_HALTED;
      end
      default: begin
        w_state_n = S_RUN;
      end
    endcase
  end

  assign imemREN     = (r_state != S_HALTED);
  assign imemaddr    = r_pc;
  assign ifid_instr  = r_instr;
  assign ifid_npc    = r_npc;
  assign ifid_valid  = r_valid;
  assign fetch_state = r_state;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, hazard, branch, jump, halt;
  logic [31:0] imemload, branch_target, jump_target;
  logic        imemREN, ifid_valid;
  logic [31:0] imemaddr, ifid_instr, ifid_npc;
  logic [1:0]  fetch_state;

  fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .hazard(hazard), .branch(branch), .jump(jump),
    .branch_target(branch_target), .jump_target(jump_target), .halt(halt),
    .imemREN(imemREN), .imemaddr(imemaddr), .ifid_instr(ifid_instr),
    .ifid_npc(ifid_npc), .ifid_valid(ifid_valid), .fetch_state(fetch_state)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic        ren;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        valid;
    logic [1:0]  st;
  } out_t;

  typedef struct {
    logic        ihit;
    logic [31:0] load;
    logic        hazard;
    logic        branch;
    logic        jump;
    logic [31:0] bt;
    logic [31:0] jt;
    logic        halt;
    out_t        exp;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  function automatic out_t mo(logic [31:0] a, logic r, logic [31:0] i,
                              logic [31:0] n, logic v, logic [1:0] s);
    out_t o;
    o.addr = a; o.ren = r; o.instr = i; o.npc = n; o.valid = v; o.st = s;
    return o;
  endfunction

  function automatic vec_t mv(logic ih, logic [31:0] ld, logic hz, logic br,
                              logic jp, logic [31:0] bt, logic [31:0] jt,
                              logic hl, out_t e);
    vec_t v;
    v.ihit = ih; v.load = ld; v.hazard = hz; v.branch = br; v.jump = jp;
    v.bt = bt; v.jt = jt; v.halt = hl; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input out_t e);
    n_vec++;
    if (imemaddr !== e.addr || imemREN !== e.ren || ifid_instr !== e.instr ||
        ifid_npc !== e.npc || ifid_valid !== e.valid || fetch_state !== e.st) begin
      n_err++;
      $display("FAIL %s: got addr=%h ren=%b instr=%h npc=%h valid=%b st=%0d, expected addr=%h ren=%b instr=%h npc=%h valid=%b st=%0d",
               name, imemaddr, imemREN, ifid_instr, ifid_npc, ifid_valid, fetch_state,
               e.addr, e.ren, e.instr, e.npc, e.valid, e.st);
    end
  endtask

  task automatic drive(input vec_t v);
    ihit = v.ihit; imemload = v.load; hazard = v.hazard; branch = v.branch;
    jump = v.jump; branch_target = v.bt; jump_target = v.jt; halt = v.halt;
  endtask

  task automatic idle_inputs();
    ihit = 0; imemload = 0; hazard = 0; branch = 0; jump = 0;
    branch_target = 0; jump_target = 0; halt = 0;
  endtask

  // Async reset pulse in mid-cycle, outputs checked while nRST is still low.
  task automatic reset_pulse(input string name);
    @(negedge CLK);
    #2 nRST = 0;
    #1 check(name, mo(32'h0, 1'b1, 32'h0, 32'h0, 1'b0, 2'd0));
    #1 nRST = 1;
  endtask

  // Reference model state: mode 0 running, 1 waiting out a stale access
  // with a parked target, 2 shut down.
  int          m_mode;
  logic [31:0] m_pc, m_pend;
  logic [31:0] m_instr, m_npc;
  logic        m_valid;

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_pend = 0; m_instr = 0; m_npc = 0; m_valid = 0;
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    logic        keep_ifid;
    tgt = {(jump ? jump_target[31:2] : branch_target[31:2]), 2'b00};
    keep_ifid = 0;
    if (m_mode == 2) begin
      // frozen
    end else if (halt) begin
      m_mode = 2;
    end else if (m_mode == 1) begin
      if (ihit) begin
        m_pc = (jump || branch) ? tgt : m_pend;
        m_mode = 0;
      end else if (jump || branch) begin
        m_pend = tgt;
      end
    end else if (jump || branch) begin
      if (ihit) m_pc = tgt;
      else begin m_pend = tgt; m_mode = 1; end
    end else if (hazard) begin
      keep_ifid = 1;
    end else if (ihit) begin
      m_instr = imemload; m_npc = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
      keep_ifid = 1;
    end
    if (!keep_ifid) begin m_instr = 0; m_npc = 0; m_valid = 0; end
  endtask

  vec_t vt[$];

  initial begin
    idle_inputs();
    nRST = 0;
    #3 check("reset", mo(32'h0, 1'b1, 32'h0, 32'h0, 1'b0, 2'd0));
    @(negedge CLK);
    nRST = 1;

    // Directed table
    vt.push_back(mv(1, 32'hA0, 0, 0, 0, 0, 0, 0, mo(32'h4,   1, 32'hA0, 32'h4,  1, 0)));
    vt.push_back(mv(1, 32'hA1, 0, 0, 0, 0, 0, 0, mo(32'h8,   1, 32'hA1, 32'h8,  1, 0)));
    vt.push_back(mv(1, 32'hA2, 1, 0, 0, 0, 0, 0, mo(32'h8,   1, 32'hA1, 32'h8,  1, 0)));
    vt.push_back(mv(1, 32'hA2, 1, 0, 0, 0, 0, 0, mo(32'h8,   1, 32'hA1, 32'h8,  1, 0)));
    vt.push_back(mv(1, 32'hA2, 0, 0, 0, 0, 0, 0, mo(32'hC,   1, 32'hA2, 32'hC,  1, 0)));
    vt.push_back(mv(1, 32'hA3, 0, 0, 0, 0, 0, 0, mo(32'h10,  1, 32'hA3, 32'h10, 1, 0)));
    vt.push_back(mv(1, 32'hBB, 0, 1, 0, 32'h40, 0, 0, mo(32'h40, 1, 0, 0, 0, 0)));
    vt.push_back(mv(1, 32'h55, 0, 0, 0, 0, 0, 0, mo(32'h44,  1, 32'h55, 32'h44, 1, 0)));
    vt.push_back(mv(1, 32'hBB, 0, 1, 1, 32'h40, 32'h80, 0, mo(32'h80, 1, 0, 0, 0, 0)));
    vt.push_back(mv(1, 32'h66, 0, 0, 0, 0, 0, 0, mo(32'h84,  1, 32'h66, 32'h84, 1, 0)));
    vt.push_back(mv(1, 32'h77, 0, 0, 0, 0, 0, 0, mo(32'h88,  1, 32'h77, 32'h88, 1, 0)));
    vt.push_back(mv(1, 32'h78, 0, 0, 0, 0, 0, 0, mo(32'h8C,  1, 32'h78, 32'h8C, 1, 0)));
    vt.push_back(mv(0, 0, 0, 0, 1, 0, 32'h103, 0, mo(32'h8C, 1, 0, 0, 0, 1)));
    vt.push_back(mv(0, 0, 1, 0, 0, 0, 0, 0, mo(32'h8C,  1, 0, 0, 0, 1)));
    vt.push_back(mv(0, 0, 0, 0, 0, 0, 0, 0, mo(32'h8C,  1, 0, 0, 0, 1)));
    vt.push_back(mv(1, 32'hDEAD, 0, 0, 0, 0, 0, 0, mo(32'h100, 1, 0, 0, 0, 0)));
    vt.push_back(mv(1, 32'h99, 0, 0, 0, 0, 0, 0, mo(32'h104, 1, 32'h99, 32'h104, 1, 0)));
    vt.push_back(mv(0, 32'h98, 0, 0, 0, 0, 0, 0, mo(32'h104, 1, 0, 0, 0, 0)));
    vt.push_back(mv(1, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, mo(32'hFFFF_FFFC, 1, 0, 0, 0, 0)));
    vt.push_back(mv(1, 32'h11, 0, 0, 0, 0, 0, 0, mo(32'h0, 1, 32'h11, 32'h0, 1, 0)));
    vt.push_back(mv(0, 0, 0, 0, 1, 0, 32'h200, 0, mo(32'h0, 1, 0, 0, 0, 1)));
    vt.push_back(mv(1, 32'h5, 0, 1, 1, 32'h40, 32'h200, 1, mo(32'h0, 0, 0, 0, 0, 2)));
    vt.push_back(mv(1, 32'h6, 0, 0, 1, 0, 32'h300, 0, mo(32'h0, 0, 0, 0, 0, 2)));

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge CLK);
      drive(vt[i]);
      @(posedge CLK);
      #1 check($sformatf("vec%0d", i), vt[i].exp);
    end

    // Halted fetch must come back on an async reset pulse.
    idle_inputs();
    reset_pulse("reset_from_halt");

    // Reset in REDIR drops the parked target and restarts at PC_INIT.
    @(negedge CLK);
    jump = 1; jump_target = 32'h500; ihit = 0;
    @(posedge CLK);
    #1 check("enter_redir", mo(32'h0, 1, 0, 0, 0, 1));
    idle_inputs();
    reset_pulse("reset_mid_redir");
    @(negedge CLK);
    ihit = 1; imemload = 32'hC0;
    @(posedge CLK);
    #1 check("restart_after_redir", mo(32'h4, 1, 32'hC0, 32'h4, 1, 0));

    // Randomized run against the reference model
    idle_inputs();
    reset_pulse("reset_random");
    model_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge CLK);
      ihit          = ($urandom_range(0, 9) < 6);
      imemload      = $urandom;
      hazard        = ($urandom_range(0, 9) < 2);
      branch        = ($urandom_range(0, 19) < 3);
      jump          = ($urandom_range(0, 19) < 2);
      branch_target = $urandom;
      jump_target   = $urandom;
      halt          = ($urandom_range(0, 79) == 0);
      model_step();
      @(posedge CLK);
      #1 check($sformatf("rand%0d", c),
               mo(m_pc, (m_mode != 2), m_instr, m_npc, m_valid, m_mode[1:0]));
      if (m_mode == 2 && $urandom_range(0, 3) == 0) begin
        idle_inputs();
        reset_pulse("reset_rand_halt");
        model_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
